bias_add_stage: RTL and testbench
=================================

Name: bias_add_stage

Overview:
- Downstream consumer of the bias buffer in the cnna accumulate path.
- For each output-channel group, it reads one 16-lane bias word from the bias RAM read port, then streams accumulator pixels through.
- Each lane gets a saturating signed bias add, and the result is forwarded with a valid/ready handshake to the requantise/write-back stage.
- Runs under an ap_start/ap_done control pair, like the other cnna stages.

Parameters:
- C_LANES, 16, number of parallel output channels per group.
- C_ACC_WIDTH, 32, signed width of each accumulator lane, bias lane and result lane.
- C_LBIAS_WIDTH, 512, bias word width; must equal C_LANES*C_ACC_WIDTH.
- C_RAM_ADDR_WIDTH, 10, width of bias RAM read address. One bias word occupies 4 consecutive addresses; word index = address[C_RAM_ADDR_WIDTH-1:2].
- C_CNT_WIDTH, 16, width of the pixel counter.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  synchronous active-high reset
- I_ap_start  in  1  level start; held high for the whole operation
- O_ap_done  out  1  operation complete
- I_cgroup_num  in  C_RAM_ADDR_WIDTH-2  number of channel groups
- I_pix_num  in  C_CNT_WIDTH  pixels per channel group
- O_braddr  out  C_RAM_ADDR_WIDTH  bias RAM read address
- I_brdata  in  C_LBIAS_WIDTH  bias RAM read data; lane k = bits [32k+31:32k]
- I_acc_valid  in  1  accumulator pixel valid
- O_acc_ready  out  1  accumulator pixel accepted
- I_acc_data  in  C_LBIAS_WIDTH  accumulator pixel, C_LANES signed lanes
- O_res_valid  out  1  result valid
- I_res_ready  in  1  downstream ready
- O_res_data  out  C_LBIAS_WIDTH  result pixel

Behaviour:
- Reset: FSM=IDLE. O_ap_done, O_acc_ready, O_res_valid, O_braddr, O_res_data all 0. Counters and bias register cleared.
- Bias RAM read latency is fixed at 2 cycles: I_brdata is valid 2 cycles after O_braddr changes.
- Reset mid-operation behaves like power-up reset. Any in-flight result is dropped.
- FSM states:
  - IDLE:
    - On rising I_ap_start: latch I_cgroup_num and I_pix_num; cg=0; pix=0.
    - If either latched count is 0, go to DONE; else go to FETCH.
  - FETCH:
    - O_braddr = {cg, 2'b00}.
    - Wait counter runs 0..2. At count 2, register I_brdata into the bias register, then go to RUN.
  - RUN:
    - O_acc_ready = !O_res_valid || I_res_ready.
    - A pixel is accepted when I_acc_valid && O_acc_ready.
    - On accept: O_res_data lane k = sat(acc_k + bias_k), computed with a 33-bit signed sum clamped to [-2^31, 2^31-1]. O_res_valid=1 the next cycle (1-cycle latency). pix increments.
    - When the accepted pixel is pix==I_pix_num-1:
      - If cg==I_cgroup_num-1, go to DRAIN.
      - Otherwise cg+1, pix=0, go to FETCH.
  - DRAIN: wait until O_res_valid==0 or I_res_ready is high, then go to DONE.
  - DONE: O_ap_done=1 while I_ap_start is high. When I_ap_start falls, go to IDLE and clear O_ap_done.
- Handshake rules:
  - O_acc_ready is 0 outside RUN.
  - O_res_valid stays high and O_res_data stays stable until I_res_ready.
  - If I_res_ready and a new accept coincide, the output register reloads in the same cycle with no bubble.
  - In RUN with I_res_ready held high, throughput is 1 pixel/cycle.
- Group switch: O_res_valid may remain pending through FETCH. The new bias must never be applied to a pixel from the previous group.
- Abort: I_ap_start falling in FETCH, RUN or DRAIN goes to IDLE next cycle. O_res_valid and O_acc_ready clear to 0.
- Wrap: O_braddr never exceeds {I_cgroup_num-1, 2'b00}.

Optional Feature:
- Macro: BIAS_ADD_RELU_EN.
- Defined: after saturation, any lane whose result is negative is forced to 0. Saturation still applies to positive overflow.
- Undefined: the signed saturated result passes through unchanged.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic add: cgroup_num=2, pix_num=3; bias words B0 lanes=100, B1 lanes=-5; acc lanes=k (lane index).
  - Required: 6 results; group0 lane k = k+100, group1 lane k = k-5.
  - Required: O_braddr sequence 0 then 4; O_ap_done rises after the 6th result is accepted.
- Saturation: bias=0x7FFFFFF0, acc=0x00000100 -> 0x7FFFFFFF. Bias=0x80000000, acc=-1 -> 0x80000000.
- Backpressure: I_res_ready toggling 1,0,0,1 with I_acc_valid held high -> O_res_data held stable while not ready, no pixels lost or duplicated, O_acc_ready low during stall.
- Zero count: pix_num=0 -> O_ap_done=1 within 2 cycles of start, no O_acc_ready, no O_res_valid.
- Abort/reset: drop I_ap_start at the 2nd pixel of group 1 -> next cycle IDLE, O_res_valid=0. Restart from cg=0 with braddr=0. Assert I_rst in RUN -> all outputs 0 the next cycle.
- RELU build: bias=-10, acc=3 -> result 0 with BIAS_ADD_RELU_EN defined, 0xFFFFFFF9 (-7) without.

Source files
------------

// File: rtl/bias_add_stage.sv
// -----------------------------------------------------------------------------
// bias_add_stage
//
// Purpose:
//   Adds a per-output-channel bias to accumulator pixels in the cnna
//   accumulate path. For every output-channel group one C_LANES-wide bias
//   word is fetched from the bias RAM. The group's accumulator pixels are then
//   streamed through a saturating signed add (one pixel per cycle) and passed
//   to the requantise/write-back stage over a valid/ready handshake.
//   An ap_start/ap_done pair controls each operation.
//
// Optional feature (compile-time macro BIAS_ADD_RELU_EN):
//   When defined, any lane whose saturated result is negative is forced to 0.
//   Latency and handshake are the same with or without the macro.
//
// Ports:
//   I_clk, I_rst     clock, synchronous active-high reset
//   I_ap_start       level start, held high for the whole operation
//   O_ap_done        operation complete (high in DONE while I_ap_start high)
//   I_cgroup_num     number of channel groups
//   I_pix_num        pixels per channel group
//   O_braddr         bias RAM read address (4 addresses per bias word)
//   I_brdata         bias RAM read data, valid 2 cycles after O_braddr changes
//   I_acc_valid / O_acc_ready / I_acc_data   accumulator pixel input
//   O_res_valid / I_res_ready / O_res_data   biased result output
// -----------------------------------------------------------------------------
module bias_add_stage #(
    parameter int C_LANES          = 16,
    parameter int C_ACC_WIDTH      = 32,
    parameter int C_LBIAS_WIDTH    = 512,
    parameter int C_RAM_ADDR_WIDTH = 10,
    parameter int C_CNT_WIDTH      = 16
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    input  logic [C_RAM_ADDR_WIDTH-3:0]   I_cgroup_num,
    input  logic [C_CNT_WIDTH-1:0]        I_pix_num,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_braddr,
    input  logic [C_LBIAS_WIDTH-1:0]      I_brdata,
    input  logic                          I_acc_valid,
    output logic                          O_acc_ready,
    input  logic [C_LBIAS_WIDTH-1:0]      I_acc_data,
    output logic                          O_res_valid,
    input  logic                          I_res_ready,
    output logic [C_LBIAS_WIDTH-1:0]      O_res_data
);

    localparam int C_CG_WIDTH = C_RAM_ADDR_WIDTH - 2;
    localparam logic [C_ACC_WIDTH-1:0] C_SAT_MAX = {1'b0, {(C_ACC_WIDTH-1){1'b1}}};
    localparam logic [C_ACC_WIDTH-1:0] C_SAT_MIN = {1'b1, {(C_ACC_WIDTH-1){1'b0}}};
    localparam logic [C_CG_WIDTH-1:0]  C_CG_ONE  = {{(C_CG_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_CNT_WIDTH-1:0] C_PIX_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                        state_reg, state_next;
    logic                          start_d_reg;
    logic [C_CG_WIDTH-1:0]         cg_num_reg;
    logic [C_CNT_WIDTH-1:0]        pix_num_reg;
    logic [C_CG_WIDTH-1:0]         cg_reg;
    logic [C_CNT_WIDTH-1:0]        pix_reg;
    logic [1:0]                    wait_reg;
    logic [C_RAM_ADDR_WIDTH-1:0]   braddr_reg;
    logic [C_LBIAS_WIDTH-1:0]      bias_reg;
    logic                          res_valid_reg;
    logic [C_LBIAS_WIDTH-1:0]      res_data_reg;

    logic                          acc_ready_c;
    logic                          ap_done_c;
    logic                          start_rise;
    logic                          accept;
    logic                          last_pix;
    logic                          last_cg;
    logic                          abort;
    logic [C_CG_WIDTH-1:0]         cg_inc;
    logic [C_LBIAS_WIDTH-1:0]      sum_all;

    assign start_rise = I_ap_start && !start_d_reg;
    assign accept     = acc_ready_c && I_acc_valid;
    assign last_pix   = (pix_reg == pix_num_reg - C_PIX_ONE);
    assign last_cg    = (cg_reg == cg_num_reg - C_CG_ONE);
    assign cg_inc     = cg_reg + C_CG_ONE;
    // Dropping I_ap_start while busy abandons the operation.
    assign abort      = !I_ap_start &&
                        (state_reg == S_FETCH || state_reg == S_RUN || state_reg == S_DRAIN);

    // ------------------------------------------------------------------
    // Per-lane saturating add. Both operands are sign-extended by one bit,
    // so overflow shows up as the top two sum bits disagreeing.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < C_LANES; gi++) begin : g_lane
        localparam int LSB = gi * C_ACC_WIDTH;
        localparam int MSB = LSB + C_ACC_WIDTH - 1;

        logic [C_ACC_WIDTH:0]   sum_w;
        logic [C_ACC_WIDTH-1:0] sat_w;

        assign sum_w = {I_acc_data[MSB], I_acc_data[MSB:LSB]} +
                       {bias_reg[MSB], bias_reg[MSB:LSB]};

        always_comb begin
            sat_w = sum_w[C_ACC_WIDTH-1:0];
            if (sum_w[C_ACC_WIDTH] != sum_w[C_ACC_WIDTH-1]) begin
                sat_w = sum_w[C_ACC_WIDTH] ? C_SAT_MIN : C_SAT_MAX;
            end
        end

`ifdef BIAS_ADD_RELU_EN
        assign sum_all[MSB:LSB] = sat_w[C_ACC_WIDTH-1] ? '0 : sat_w;
`else
        assign sum_all[MSB:LSB] = sat_w;
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_rise) begin
                    if (I_cgroup_num == '0 || I_pix_num == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (wait_reg == 2'd2) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (accept && last_pix) begin
                    state_next = last_cg ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (!res_valid_reg || I_res_ready) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!I_ap_start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. acc_ready is gated by I_ap_start so that no pixel is
    // taken in the cycle an abort is being signalled.
    // ------------------------------------------------------------------
    always_comb begin
        acc_ready_c = 1'b0;
        ap_done_c   = 1'b0;
        case (state_reg)
            S_RUN:   acc_ready_c = I_ap_start && (!res_valid_reg || I_res_ready);
            S_DONE:  ap_done_c   = I_ap_start;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, bias fetch and the result register
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            start_d_reg   <= 1'b0;
            cg_num_reg    <= '0;
            pix_num_reg   <= '0;
            cg_reg        <= '0;
            pix_reg       <= '0;
            wait_reg      <= '0;
            braddr_reg    <= '0;
            bias_reg      <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            start_d_reg <= I_ap_start;

            case (state_reg)
                S_IDLE: begin
                    if (start_rise) begin
                        cg_num_reg  <= I_cgroup_num;
                        pix_num_reg <= I_pix_num;
                        cg_reg      <= '0;
                        pix_reg     <= '0;
                        wait_reg    <= '0;
                        braddr_reg  <= '0;
                    end
                end
                S_FETCH: begin
                    // The RAM answers two cycles after the address moved,
                    // so the word is taken on the third FETCH cycle.
                    if (wait_reg == 2'd2) begin
                        bias_reg <= I_brdata;
                        wait_reg <= '0;
                    end else begin
                        wait_reg <= wait_reg + 2'd1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            pix_reg <= '0;
                            if (!last_cg) begin
                                cg_reg     <= cg_inc;
                                braddr_reg <= {cg_inc, 2'b00};
                                wait_reg   <= '0;
                            end
                        end else begin
                            pix_reg <= pix_reg + C_PIX_ONE;
                        end
                    end
                end
                default: ;
            endcase

            // The result register may still be pending across a group
            // switch; it was computed with the old bias at accept time.
            if (abort) begin
                res_valid_reg <= 1'b0;
            end else if (accept) begin
                res_valid_reg <= 1'b1;
                res_data_reg  <= sum_all;
            end else if (I_res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign O_ap_done   = ap_done_c;
    assign O_acc_ready = acc_ready_c;
    assign O_braddr    = braddr_reg;
    assign O_res_valid = res_valid_reg;
    assign O_res_data  = res_data_reg;

endmodule

// File: tb/tb_bias_add_stage.sv
// -----------------------------------------------------------------------------
// tb_bias_add_stage
//
// Directed testbench for bias_add_stage. Includes a 2-cycle-latency bias RAM
// model, and scenario tasks that each drive stimulus and check results inline.
// Expected values for the BIAS_ADD_RELU_EN build follow the same macro.
// -----------------------------------------------------------------------------
module tb_bias_add_stage;

    localparam int LANES = 16;
    localparam int W     = 32;
    localparam int LW    = 512;
    localparam int AW    = 10;
    localparam int CW    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              ap_start;
    logic              ap_done;
    logic [AW-3:0]     cgroup_num;
    logic [CW-1:0]     pix_num;
    logic [AW-1:0]     braddr;
    logic [LW-1:0]     brdata;
    logic              acc_valid;
    logic              acc_ready;
    logic [LW-1:0]     acc_data;
    logic              res_valid;
    logic              res_ready;
    logic [LW-1:0]     res_data;

    logic [LW-1:0]     mem [0:255];
    logic [LW-1:0]     rd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Bias RAM: data appears two clock edges after the address.
    always @(posedge clk) begin
        rd1    <= mem[braddr[AW-1:2]];
        brdata <= rd1;
    end

    bias_add_stage #(
        .C_LANES(LANES), .C_ACC_WIDTH(W), .C_LBIAS_WIDTH(LW),
        .C_RAM_ADDR_WIDTH(AW), .C_CNT_WIDTH(CW)
    ) dut (
        .I_clk(clk), .I_rst(rst),
        .I_ap_start(ap_start), .O_ap_done(ap_done),
        .I_cgroup_num(cgroup_num), .I_pix_num(pix_num),
        .O_braddr(braddr), .I_brdata(brdata),
        .I_acc_valid(acc_valid), .O_acc_ready(acc_ready), .I_acc_data(acc_data),
        .O_res_valid(res_valid), .I_res_ready(res_ready), .O_res_data(res_data)
    );

    function automatic logic [LW-1:0] rep(input logic [W-1:0] v);
        logic [LW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*W +: W] = v;
        return r;
    endfunction

    // lane k = k + off
    function automatic logic [LW-1:0] ramp(input logic [W-1:0] off);
        logic [LW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*W +: W] = off + 32'(k);
        return r;
    endfunction

    // Expected output for a vector of already-saturated signed lanes.
    function automatic logic [LW-1:0] exp_out(input logic [LW-1:0] v);
        logic [LW-1:0] r;
        r = v;
`ifdef BIAS_ADD_RELU_EN
        for (int k = 0; k < LANES; k++) begin
            if (r[k*W + W - 1]) r[k*W +: W] = '0;
        end
`endif
        return r;
    endfunction

    task automatic idle_inputs();
        ap_start   = 1'b0;
        acc_valid  = 1'b0;
        res_ready  = 1'b0;
        acc_data   = '0;
        cgroup_num = '0;
        pix_num    = '0;
    endtask

    task automatic end_op();
        @(negedge clk);
        ap_start  = 1'b0;
        acc_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One group, one pixel; returns the first result seen.
    task automatic run_single(input logic [LW-1:0] bias, input logic [LW-1:0] acc,
                              output logic [LW-1:0] got, output bit ok);
        bit seen_res;
        bit seen_done;
        mem[0] = bias;
        seen_res  = 1'b0;
        seen_done = 1'b0;
        got = '0;
        @(negedge clk);
        cgroup_num = 8'd1; pix_num = 16'd1; ap_start = 1'b1;
        acc_valid = 1'b1; acc_data = acc; res_ready = 1'b1;
        for (int c = 0; c < 50 && !seen_done; c++) begin
            #1;
            if (res_valid && !seen_res) begin
                got = res_data;
                seen_res = 1'b1;
            end
            if (ap_done) seen_done = 1'b1;
            @(negedge clk);
        end
        ok = seen_res && seen_done;
        end_op();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (ap_done !== 1'b0)   begin n_fail++; $display("FAIL reset_ap_done got=%b exp=0", ap_done); end
        n_tests++; if (acc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_acc_ready got=%b exp=0", acc_ready); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        n_tests++; if (braddr !== '0)      begin n_fail++; $display("FAIL reset_braddr got=%h exp=0", braddr); end
        n_tests++; if (res_data !== '0)    begin n_fail++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic_add();
        logic [AW-1:0] addr_seq[$];
        logic [AW-1:0] last_addr;
        logic [LW-1:0] exp_v;
        int  n_res;
        bit  got_done;
        mem[0] = rep(32'd100);
        mem[1] = rep(32'hFFFF_FFFB);
        n_res = 0;
        got_done = 1'b0;
        @(negedge clk);
        cgroup_num = 8'd2; pix_num = 16'd3; ap_start = 1'b1;
        acc_valid = 1'b1; acc_data = ramp(32'd0); res_ready = 1'b1;
        last_addr = braddr;
        addr_seq.push_back(braddr);
        for (int c = 0; c < 200 && !got_done; c++) begin
            #1;
            if (braddr !== last_addr) begin
                addr_seq.push_back(braddr);
                last_addr = braddr;
            end
            if (ap_done) begin
                got_done = 1'b1;
                n_tests++;
                if (n_res != 6) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=6", n_res); end
            end else if (res_valid && res_ready) begin
                exp_v = (n_res < 3) ? exp_out(ramp(32'd100)) : exp_out(ramp(32'hFFFF_FFFB));
                n_tests++;
                if (res_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL basic_res%0d got=%h exp=%h", n_res, res_data, exp_v);
                end else begin
                    $display("[TB] basic result %0d lane0=%h lane15=%h", n_res, res_data[W-1:0], res_data[LW-1 -: W]);
                end
                n_res++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!got_done) begin n_fail++; $display("FAIL basic_timeout got=no_done exp=done"); end
        n_tests++;
        if (addr_seq.size() != 2 || addr_seq[0] !== 10'd0 || addr_seq[1] !== 10'd4) begin
            n_fail++;
            $display("FAIL basic_braddr_seq got_len=%0d first=%h last=%h exp=0,4",
                     addr_seq.size(), addr_seq[0], addr_seq[addr_seq.size()-1]);
        end
        ap_start = 1'b0;
        acc_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (ap_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_clear got=%b exp=0", ap_done); end
        end_op();
    endtask

    task automatic test_saturation();
        logic [LW-1:0] bias;
        logic [LW-1:0] acc;
        logic [LW-1:0] exp_v;
        logic [LW-1:0] got;
        bit ok;
        for (int k = 0; k < LANES; k++) begin
            bias[k*W +: W]  = (k % 2 == 0) ? 32'h7FFF_FFF0 : 32'h8000_0000;
            acc[k*W +: W]   = (k % 2 == 0) ? 32'h0000_0100 : 32'hFFFF_FFFF;
            exp_v[k*W +: W] = (k % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        exp_v = exp_out(exp_v);
        run_single(bias, acc, got, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL sat_timeout got=no_result exp=result"); end
        n_tests++;
        if (got[W-1:0] !== exp_v[W-1:0]) begin
            n_fail++; $display("FAIL sat_pos got=%h exp=%h", got[W-1:0], exp_v[W-1:0]);
        end
        n_tests++;
        if (got[2*W-1:W] !== exp_v[2*W-1:W]) begin
            n_fail++; $display("FAIL sat_neg got=%h exp=%h", got[2*W-1:W], exp_v[2*W-1:W]);
        end
        n_tests++;
        if (got !== exp_v) begin n_fail++; $display("FAIL sat_all got=%h exp=%h", got, exp_v); end
        $display("[TB] saturation lane0=%h lane1=%h", got[W-1:0], got[2*W-1:W]);
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [LW-1:0] held;
        bit held_valid;
        int sent;
        int n_out;
        bit got_done;
        int n_stall;
        mem[0] = rep(32'd0);
        sent = 0; n_out = 0; held_valid = 1'b0; got_done = 1'b0; n_stall = 0;
        held = '0;
        @(negedge clk);
        cgroup_num = 8'd1; pix_num = 16'd4; ap_start = 1'b1;
        for (int c = 0; c < 200 && !got_done; c++) begin
            res_ready = pat[c % 4];
            acc_valid = (sent < 4);
            acc_data  = rep(32'(sent + 1));
            #1;
            if (held_valid) begin
                n_tests++;
                if (res_valid !== 1'b1 || res_data !== held) begin
                    n_fail++;
                    $display("FAIL bp_stable valid=%b got=%h exp=%h", res_valid, res_data[W-1:0], held[W-1:0]);
                end
            end
            if (res_valid && !res_ready) begin
                n_stall++;
                n_tests++;
                if (acc_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall got=%b exp=0", acc_ready); end
                held_valid = 1'b1;
                held = res_data;
            end else begin
                held_valid = 1'b0;
            end
            if (res_valid && res_ready) begin
                n_tests++;
                if (res_data !== rep(32'(n_out + 1))) begin
                    n_fail++;
                    $display("FAIL bp_res%0d got=%h exp=%h", n_out, res_data[W-1:0], 32'(n_out + 1));
                end else begin
                    $display("[TB] backpressure result %0d lane0=%h", n_out, res_data[W-1:0]);
                end
                n_out++;
            end
            if (acc_ready && acc_valid) sent++;
            if (ap_done) got_done = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (!got_done || n_out != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL bp_count done=%b got_out=%0d sent=%0d exp=4", got_done, n_out, sent);
        end
        n_tests++;
        if (n_stall == 0) begin n_fail++; $display("FAIL bp_no_stall got=0 exp=nonzero"); end
        end_op();
    endtask

    task automatic test_zero_count();
        logic [AW-3:0] cg_tab [2] = '{8'd3, 8'd0};
        logic [CW-1:0] px_tab [2] = '{16'd0, 16'd5};
        bit seen;
        for (int t = 0; t < 2; t++) begin
            seen = 1'b0;
            @(negedge clk);
            cgroup_num = cg_tab[t]; pix_num = px_tab[t]; ap_start = 1'b1;
            acc_valid = 1'b1; res_ready = 1'b1;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                #1;
                n_tests++;
                if (acc_ready !== 1'b0 || res_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero%0d_handshake acc_ready=%b res_valid=%b exp=0,0", t, acc_ready, res_valid);
                end
                if (ap_done) seen = 1'b1;
            end
            n_tests++;
            if (!seen) begin n_fail++; $display("FAIL zero%0d_done got=0 exp=1", t); end
            $display("[TB] zero count case %0d done=%b", t, seen);
            end_op();
        end
    endtask

    task automatic test_abort_reset();
        int  accepts;
        bit  aborted;
        bit  seen;
        mem[0] = rep(32'd100);
        mem[1] = rep(32'hFFFF_FFFB);
        accepts = 0; aborted = 1'b0; seen = 1'b0;
        @(negedge clk);
        cgroup_num = 8'd2; pix_num = 16'd3; ap_start = 1'b1;
        acc_valid = 1'b1; acc_data = ramp(32'd0); res_ready = 1'b1;
        for (int c = 0; c < 100 && !aborted; c++) begin
            #1;
            if (acc_ready && acc_valid && accepts == 4) begin
                // second pixel of group 1 is on offer: abort with a result pending
                ap_start  = 1'b0;
                res_ready = 1'b0;
                aborted   = 1'b1;
            end else begin
                if (acc_ready && acc_valid) accepts++;
                @(negedge clk);
            end
        end
        n_tests++;
        if (!aborted) begin n_fail++; $display("FAIL abort_reach got=%0d exp=4", accepts); end
        @(posedge clk);
        #1;
        n_tests++;
        if (res_valid !== 1'b0 || acc_ready !== 1'b0 || ap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs res_valid=%b acc_ready=%b ap_done=%b exp=0,0,0", res_valid, acc_ready, ap_done);
        end
        $display("[TB] abort after %0d accepts", accepts);

        // restart from group 0
        @(negedge clk);
        ap_start = 1'b1; res_ready = 1'b1; acc_valid = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (braddr !== 10'd0) begin n_fail++; $display("FAIL restart_braddr got=%h exp=0", braddr); end
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        n_tests++;
        if (!seen || res_data !== exp_out(ramp(32'd100))) begin
            n_fail++;
            $display("FAIL restart_res seen=%b got=%h exp=%h", seen, res_data[W-1:0], 32'd100);
        end
        n_tests++;
        if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL restart_in_run got=%b exp=1", acc_ready); end

        // reset while running
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (ap_done !== 1'b0 || acc_ready !== 1'b0 || res_valid !== 1'b0 ||
            braddr !== '0 || res_data !== '0) begin
            n_fail++;
            $display("FAIL run_reset done=%b ready=%b valid=%b braddr=%h data0=%h exp=all0",
                     ap_done, acc_ready, res_valid, braddr, res_data[W-1:0]);
        end
        $display("[TB] reset in RUN checked");
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_relu();
        logic [LW-1:0] got;
        logic [W-1:0]  exp_lane;
        bit ok;
`ifdef BIAS_ADD_RELU_EN
        exp_lane = 32'h0000_0000;
`else
        exp_lane = 32'hFFFF_FFF9;
`endif
        run_single(rep(32'hFFFF_FFF6), rep(32'd3), got, ok);
        n_tests++;
        if (!ok || got !== rep(exp_lane)) begin
            n_fail++;
            $display("FAIL relu ok=%b got=%h exp=%h", ok, got[W-1:0], exp_lane);
        end
        $display("[TB] relu lane0=%h", got[W-1:0]);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_add();
        test_saturation();
        test_backpressure();
        test_zero_count();
        test_abort_reset();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
